seq_mul: RTL and testbench

SEQ_MUL -- requirements
Module: seq_mul

---
 rtl/seq_mul_pkg.sv | 11 +
 rtl/seq_mul_datapath.sv | 44 ++++
 rtl/seq_mul.sv | 80 ++++++++
 tb/tb_seq_mul.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package seq_mul_pkg;

   localparam int WIDTH_DEF = 4;

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

endpackage

// File: rtl/seq_mul_datapath.sv
// Operand shift registers, accumulator and adder; consumes one multiplier bit per step.
module seq_mul_datapath
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] sum
);

   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;

   // Accumulator value after the current step; on the last step this is the product.
   always_comb begin
      sum = acc;
      if (mplier[0]) begin
         sum = acc + mcand;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (load) begin
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         acc    <= '0;
      end else if (step) begin
         acc    <= sum;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

endmodule

// File: rtl/seq_mul.sv
// Unsigned sequential multiplier: IDLE/CALC control, iteration counter and result register.
module seq_mul
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] op,
   output logic               busy,
   output logic               done
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t             state, state_next;
   logic [CW-1:0]      cnt;
   logic               load;
   logic               step;
   logic               last;
   logic [2*WIDTH-1:0] sum;

   // Start is only honoured in IDLE, so a request while busy is dropped.
   assign load = (state == IDLE) && start;
   assign step = (state == CALC);
   assign last = step && (cnt == CW'(WIDTH - 1));
   assign busy = step;

   seq_mul_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .step  (step),
      .a     (a),
      .b     (b),
      .sum   (sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = CALC;
         CALC: if (last)  state_next = IDLE;
         default:         state_next = IDLE;
      endcase
   end

   // op only updates on the final step, so partial sums never reach the output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         op   <= '0;
         done <= 1'b0;
      end else begin
         done <= last;
         if (load) begin
            cnt <= '0;
         end else if (step) begin
            cnt <= cnt + CW'(1);
         end
         if (last) begin
            op <= sum;
         end
      end
   end

endmodule

// File: tb/tb_seq_mul.sv
// Directed bench for seq_mul at WIDTH=4 with hand-computed products.
module tb_seq_mul;

   localparam int W = 4;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [2*W-1:0] op;
   logic           busy;
   logic           done;

   int checks;
   int errors;

   seq_mul #(
      .WIDTH (W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .op    (op),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Issue a request, follow it through WIDTH edges and check the result in the done cycle.
   task automatic run(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic [2*W-1:0] exp);
      start = 1'b1;
      a     = ia;
      b     = ib;
      tick();
      start = 1'b0;
      a     = 4'hA;
      b     = 4'h6;
      chk({tag, "_busy_capture"}, 32'(busy), 32'd1);
      for (int i = 1; i < W; i++) begin
         tick();
         chk({tag, "_nodone"}, 32'(done), 32'd0);
         chk({tag, "_busy"}, 32'(busy), 32'd1);
      end
      tick();
      chk({tag, "_op"}, 32'(op), 32'(exp));
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      a      = '0;
      b      = '0;
      #12;
      chk("rst_op", 32'(op), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      #3 rst_n = 1'b1;
      tick();

      // 5*9, operands changed right after capture; op must hold afterwards
      start = 1'b1; a = 4'd5; b = 4'd9;
      tick();
      start = 1'b0; a = '0; b = '0;
      chk("t1_busy_capture", 32'(busy), 32'd1);
      chk("t1_op_hidden0", 32'(op), 32'd0);
      for (int i = 1; i < W; i++) begin
         tick();
         chk("t1_op_hidden", 32'(op), 32'd0);
         chk("t1_nodone", 32'(done), 32'd0);
      end
      tick();
      chk("t1_op", 32'(op), 32'd45);
      chk("t1_done", 32'(done), 32'd1);
      tick();
      chk("t1_done_drop", 32'(done), 32'd0);
      chk("t1_op_hold", 32'(op), 32'd45);
      tick();

      run("t2", 4'd13, 4'd5, 8'd65);
      tick();
      run("t3", 4'd15, 4'd15, 8'd225);
      tick();
      run("t4", 4'd0, 4'd11, 8'd0);
      tick();
      chk("t4_done_drop", 32'(done), 32'd0);

      // Second start two cycles into an operation is dropped
      start = 1'b1; a = 4'd5; b = 4'd9;
      tick();
      start = 1'b0; a = '0; b = '0;
      tick();
      start = 1'b1; a = 4'd3; b = 4'd3;
      tick();
      start = 1'b0;
      chk("t5_busy_mid", 32'(busy), 32'd1);
      tick();
      chk("t5_busy_late", 32'(busy), 32'd1);
      chk("t5_nodone", 32'(done), 32'd0);
      tick();
      chk("t5_op", 32'(op), 32'd45);
      chk("t5_done", 32'(done), 32'd1);
      tick();
      chk("t5_no_restart", 32'(busy), 32'd0);
      chk("t5_op_hold", 32'(op), 32'd45);

      // Back-to-back: second start issued in the done cycle
      run("t6a", 4'd6, 4'd7, 8'd42);
      run("t6b", 4'd2, 4'd7, 8'd14);
      tick();

      // Reset mid-calculation aborts and clears op
      start = 1'b1; a = 4'd7; b = 4'd7;
      tick();
      start = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("t7_rst_op", 32'(op), 32'd0);
      chk("t7_rst_busy", 32'(busy), 32'd0);
      chk("t7_rst_done", 32'(done), 32'd0);
      #4 rst_n = 1'b1;
      for (int i = 0; i < W + 1; i++) begin
         tick();
         chk("t7_no_done", 32'(done), 32'd0);
         chk("t7_op_zero", 32'(op), 32'd0);
      end

      run("t8", 4'd3, 4'd4, 8'd12);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
